// File: rtl/swap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : swap_pkg
//  Description : Shared types and default constants for the swap tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package swap_pkg;

  // Tracker FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } swap_state_e;

  // Consecutive consistent beats needed to declare lock
  localparam int LOCK_N_DEF = 4;

  // Width of the locked-mismatch counter
  localparam int CNT_W_DEF  = 8;

endpackage : swap_pkg
`default_nettype wire

// File: rtl/swap_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : swap_sat_cnt
//  Description : Saturating up-counter. A clear wins over the old value but
//                the increment of the same cycle is still honoured, so a
//                clear coincident with an increment leaves the count at one.
//  Revision    : 1.0 - initial release
// ============================================================================
module swap_sat_cnt
  import swap_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;

  // Clear-then-increment counter that sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= inc_i ? c_one : '0;
    end else if (inc_i && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign cnt_o = r_cnt;

endmodule : swap_sat_cnt
`default_nettype wire

// File: rtl/swap_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : swap_tracker
//  Description : Locks onto a source that alternates (A,B),(B,A),... on each
//                valid beat, recovers the seed pair, predicts the next pair
//                and counts mismatches seen while locked.
//  Revision    : 1.0 - initial release
// ============================================================================
module swap_tracker
  import swap_pkg::*;
#(
  parameter int LOCK_N = LOCK_N_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             clr_i,
  output logic             lock_o,
  output logic             seed_a_o,
  output logic             seed_b_o,
  output logic             phase_o,
  output logic             exp_a_o,
  output logic             exp_b_o,
  output logic             sym_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  // Run counter is 4 bits wide, enough for the legal LOCK_N range
  localparam logic [3:0] c_lock_n = 4'(LOCK_N);
  localparam logic [3:0] c_run_1  = 4'd1;

  swap_state_e r_state;
  swap_state_e w_state_nxt;

  logic       r_seed_a, r_seed_b, r_phase;
  logic [3:0] r_run;
  logic       r_lock, r_exp_a, r_exp_b, r_sym, r_err;

  logic       w_seed_a_nxt, w_seed_b_nxt, w_phase_nxt;
  logic [3:0] w_run_nxt;
  logic       w_lock_nxt, w_exp_a_nxt, w_exp_b_nxt, w_sym_nxt, w_err_nxt;

  logic       w_exp_a, w_exp_b, w_match, w_lock_hit;
  logic [3:0] w_run_inc;

  // Prediction for the current beat: phase 0 expects the swapped seed
  assign w_exp_a    = r_phase ? r_seed_a : r_seed_b;
  assign w_exp_b    = r_phase ? r_seed_b : r_seed_a;
  assign w_match    = (a_i == w_exp_a) && (b_i == w_exp_b);
  assign w_run_inc  = r_run + c_run_1;
  assign w_lock_hit = (w_run_inc == c_lock_n);

  // State register; reset drops straight back to HUNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision, advanced only by valid beats
  always_comb begin
    w_state_nxt = r_state;
    if (vld_i) begin
      case (r_state)
        HUNT:    w_state_nxt = ACQ;
        ACQ:     w_state_nxt = (w_match && w_lock_hit) ? LOCKED : ACQ;
        LOCKED:  w_state_nxt = w_match ? LOCKED : ACQ;
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // Datapath and output next values; a mismatch outside lock silently reseeds
  always_comb begin
    w_seed_a_nxt = r_seed_a;
    w_seed_b_nxt = r_seed_b;
    w_phase_nxt  = r_phase;
    w_run_nxt    = r_run;
    w_err_nxt    = 1'b0;
    if (vld_i) begin
      if ((r_state == HUNT) || !w_match) begin
        w_seed_a_nxt = a_i;
        w_seed_b_nxt = b_i;
        w_phase_nxt  = 1'b0;
        w_run_nxt    = c_run_1;
        w_err_nxt    = (r_state == LOCKED);
      end else begin
        w_phase_nxt = ~r_phase;
        if (r_state == ACQ) begin
          w_run_nxt = w_run_inc;
        end
      end
    end
    w_lock_nxt  = (w_state_nxt == LOCKED);
    w_sym_nxt   = w_lock_nxt && (w_seed_a_nxt == w_seed_b_nxt);
    w_exp_a_nxt = 1'b0;
    w_exp_b_nxt = 1'b0;
    if (w_state_nxt != HUNT) begin
      w_exp_a_nxt = w_phase_nxt ? w_seed_a_nxt : w_seed_b_nxt;
      w_exp_b_nxt = w_phase_nxt ? w_seed_b_nxt : w_seed_a_nxt;
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed_a <= 1'b0;
      r_seed_b <= 1'b0;
      r_phase  <= 1'b0;
      r_run    <= 4'd0;
      r_lock   <= 1'b0;
      r_exp_a  <= 1'b0;
      r_exp_b  <= 1'b0;
      r_sym    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_seed_a <= w_seed_a_nxt;
      r_seed_b <= w_seed_b_nxt;
      r_phase  <= w_phase_nxt;
      r_run    <= w_run_nxt;
      r_lock   <= w_lock_nxt;
      r_exp_a  <= w_exp_a_nxt;
      r_exp_b  <= w_exp_b_nxt;
      r_sym    <= w_sym_nxt;
      r_err    <= w_err_nxt;
    end
  end

  swap_sat_cnt #(
    .WIDTH (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_i),
    .inc_i (w_err_nxt),
    .cnt_o (err_cnt_o)
  );

  assign lock_o   = r_lock;
  assign seed_a_o = r_seed_a;
  assign seed_b_o = r_seed_b;
  assign phase_o  = r_phase;
  assign exp_a_o  = r_exp_a;
  assign exp_b_o  = r_exp_b;
  assign sym_o    = r_sym;
  assign err_o    = r_err;

endmodule : swap_tracker
`default_nettype wire

// File: tb/tb_swap_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_swap_tracker
//  Description : Directed bench for swap_tracker (LOCK_N=4, CNT_W=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_swap_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld_i = 1'b0;
  logic       a_i = 1'b0;
  logic       b_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       lock_o, seed_a_o, seed_b_o, phase_o, exp_a_o, exp_b_o, sym_o, err_o;
  logic [7:0] err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  swap_tracker #(
    .LOCK_N (4),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_i     (vld_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .clr_i     (clr_i),
    .lock_o    (lock_o),
    .seed_a_o  (seed_a_o),
    .seed_b_o  (seed_b_o),
    .phase_o   (phase_o),
    .exp_a_o   (exp_a_o),
    .exp_b_o   (exp_b_o),
    .sym_o     (sym_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o)
  );

  // Flag vector: lock, seed_a, seed_b, phase, exp_a, exp_b, sym, err
  function automatic logic [7:0] flags();
    return {lock_o, seed_a_o, seed_b_o, phase_o, exp_a_o, exp_b_o, sym_o, err_o};
  endfunction

  // One clock with the given inputs; outputs are sampled 1 ns after the edge
  task automatic beat(input logic v, input logic a, input logic b, input logic c);
    vld_i = v; a_i = a; b_i = b; clr_i = c;
    @(posedge clk);
    #1;
    vld_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic do_reset();
    vld_i = 1'b0; a_i = 1'b0; b_i = 1'b0; clr_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    vld_i = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({flags(), err_cnt_o} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got flags=%b cnt=%0d, want 0/0", flags(), err_cnt_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_lock();
    do_reset();
    beat(1, 0, 1, 0);
    n_checks++;
    if (flags() !== 8'b0_01_0_10_0_0) begin
      n_fail++;
      $display("FAIL basic_seed_capture: got %b want %b", flags(), 8'b0_01_0_10_0_0);
    end
    beat(1, 1, 0, 0);
    beat(1, 0, 1, 0);
    n_checks++;
    if (flags() !== 8'b0_01_0_10_0_0) begin
      n_fail++;
      $display("FAIL basic_no_lock_run3: got %b want %b", flags(), 8'b0_01_0_10_0_0);
    end
    beat(1, 1, 0, 0);
    n_checks++;
    if ({flags(), err_cnt_o} !== {8'b1_01_1_01_0_0, 8'd0}) begin
      n_fail++;
      $display("FAIL basic_lock: got flags=%b cnt=%0d want %b/0", flags(), err_cnt_o, 8'b1_01_1_01_0_0);
    end
  endtask

  task automatic test_locked_error();
    // Continues from the locked 01/10 state; next expected pair is 01
    beat(1, 1, 1, 0);
    n_checks++;
    if ({flags(), err_cnt_o} !== {8'b0_11_0_11_0_1, 8'd1}) begin
      n_fail++;
      $display("FAIL err_inject: got flags=%b cnt=%0d want %b/1", flags(), err_cnt_o, 8'b0_11_0_11_0_1);
    end
    beat(0, 0, 0, 0);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_single_pulse: got err_o=%b want 0", err_o);
    end
    beat(1, 1, 1, 0);
    beat(1, 1, 1, 0);
    n_checks++;
    if (lock_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sym_early_lock: got lock_o=%b want 0", lock_o);
    end
    beat(1, 1, 1, 0);
    n_checks++;
    if ({flags(), err_cnt_o} !== {8'b1_11_1_11_1_0, 8'd1}) begin
      n_fail++;
      $display("FAIL sym_relock: got flags=%b cnt=%0d want %b/1", flags(), err_cnt_o, 8'b1_11_1_11_1_0);
    end
  endtask

  task automatic test_gapped_valid();
    do_reset();
    beat(1, 0, 1, 0);
    beat(1, 1, 0, 0);
    beat(1, 0, 1, 0);
    beat(1, 1, 0, 0);
    beat(1, 0, 1, 0);
    n_checks++;
    if (flags() !== 8'b1_01_0_10_0_0) begin
      n_fail++;
      $display("FAIL gap_beat1: got %b want %b", flags(), 8'b1_01_0_10_0_0);
    end
    beat(0, 1, 1, 0);
    beat(0, 1, 1, 0);
    n_checks++;
    if (flags() !== 8'b1_01_0_10_0_0) begin
      n_fail++;
      $display("FAIL gap_hold: got %b want %b", flags(), 8'b1_01_0_10_0_0);
    end
    beat(1, 1, 0, 0);
    n_checks++;
    if ({flags(), err_cnt_o} !== {8'b1_01_1_01_0_0, 8'd0}) begin
      n_fail++;
      $display("FAIL gap_beat2: got flags=%b cnt=%0d want %b/0", flags(), err_cnt_o, 8'b1_01_1_01_0_0);
    end
  endtask

  task automatic test_saturation();
    logic x;
    do_reset();
    repeat (4) beat(1, 1, 1, 0);
    for (int i = 0; i < 300; i++) begin
      x = i[0];
      repeat (4) beat(1, x, x, 0);
      if (i == 253) begin
        n_checks++;
        if (err_cnt_o !== 8'd254) begin
          n_fail++;
          $display("FAIL sat_count_254: got %0d want 254", err_cnt_o);
        end
      end
    end
    n_checks++;
    if ({lock_o, err_cnt_o} !== {1'b1, 8'd255}) begin
      n_fail++;
      $display("FAIL sat_hold_255: got lock=%b cnt=%0d want 1/255", lock_o, err_cnt_o);
    end
    // Locked on 11; a 00 beat with clear in the same cycle
    beat(1, 0, 0, 1);
    n_checks++;
    if ({err_o, err_cnt_o} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL clr_with_err: got err=%b cnt=%0d want 1/1", err_o, err_cnt_o);
    end
    repeat (3) beat(1, 0, 0, 0);
    beat(0, 0, 0, 1);
    n_checks++;
    if ({lock_o, err_cnt_o} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL clr_alone: got lock=%b cnt=%0d want 1/0", lock_o, err_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    beat(1, 0, 1, 0);
    beat(1, 1, 0, 0);
    beat(1, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({flags(), err_cnt_o} !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: got flags=%b cnt=%0d want 0/0", flags(), err_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(1, 1, 0, 0);
    n_checks++;
    if (flags() !== 8'b0_10_0_01_0_0) begin
      n_fail++;
      $display("FAIL post_reset_capture: got %b want %b", flags(), 8'b0_10_0_01_0_0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    beat(1, 0, 1, 0);
    beat(1, 0, 1, 0);
    n_checks++;
    if ({flags(), err_cnt_o} !== {8'b0_01_0_10_0_0, 8'd0}) begin
      n_fail++;
      $display("FAIL acq_recapture: got flags=%b cnt=%0d want %b/0", flags(), err_cnt_o, 8'b0_01_0_10_0_0);
    end
    beat(1, 1, 0, 0);
    beat(1, 0, 1, 0);
    n_checks++;
    if (lock_o !== 1'b0) begin
      n_fail++;
      $display("FAIL recapture_early_lock: got lock_o=%b want 0", lock_o);
    end
    beat(1, 1, 0, 0);
    n_checks++;
    if ({lock_o, err_cnt_o} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL recapture_lock: got lock=%b cnt=%0d want 1/0", lock_o, err_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_lock();
    test_locked_error();
    test_gapped_valid();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_swap_tracker
`default_nettype wire
